// File: rtl/deci_bcd_pkg.sv
// Shared constants and types for the decimal BCD key accumulator.
//   DIGIT_W            : bits per BCD digit
//   KEY_W              : width of the one-hot decimal key
//   DEFAULT_NUM_DIGITS : default accumulator depth in digits
//   state_e            : top-level FSM states
package deci_bcd_pkg;

  localparam int unsigned DIGIT_W            = 4;
  localparam int unsigned KEY_W              = 10;
  localparam int unsigned DEFAULT_NUM_DIGITS = 4;

  typedef enum logic {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage : deci_bcd_pkg

// File: rtl/dec_onehot_enc.sv
// Combinational decimal key decoder.
//   key_in [KEY_W-1:0]  : bit i set means digit i
//   digit  [DIGIT_W-1:0]: decoded digit (highest set index)
//   valid               : digit is usable under PRIORITY_MODE
//   multi               : more than one key bit is set
// PRIORITY_MODE=0 rejects multi-hot keys; PRIORITY_MODE=1 lets the highest index win.
module dec_onehot_enc
  import deci_bcd_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic [KEY_W-1:0]   key_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               valid,
  output logic               multi
);

  logic [3:0] w_ones;

  // Popcount and highest-set-index scan in one pass; later bits overwrite earlier ones.
  always_comb begin
    w_ones = '0;
    digit  = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (key_in[i]) begin
        w_ones = w_ones + 4'd1;
        digit  = DIGIT_W'(i);
      end
    end
  end

  always_comb begin
    multi = (w_ones > 4'd1);
    valid = (w_ones == 4'd1) || (multi && (PRIORITY_MODE == 1));
  end

endmodule : dec_onehot_enc

// File: rtl/deci_bcd_accum.sv
// Decimal keypad accumulator: shifts BCD digits in from a one-hot key, commits
// the number on enter and holds it until the consumer accepts it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   key_in/key_valid      : decimal key offer; key_ready says it is taken this cycle
//   enter                 : commit strobe
//   clear                 : synchronous flush, highest priority
//   acc_bcd/acc_count     : live accumulator (LSD in [3:0]) and its digit count
//   out_bcd/out_count     : committed result; out_valid/out_ready handshake
//   err                   : one-cycle pulse when an invalid key was dropped
//   ovf                   : sticky, a digit was dropped because the accumulator was full
module deci_bcd_accum
  import deci_bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [KEY_W-1:0]                  key_in,
  input  logic                              key_valid,
  output logic                              key_ready,
  input  logic                              enter,
  input  logic                              clear,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     acc_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   acc_count,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     out_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   out_count,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err,
  output logic                              ovf
);

  localparam int unsigned ACC_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_out_bcd;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_valid;
  logic               r_err;
  logic               r_ovf;

  logic [DIGIT_W-1:0] w_digit;
  logic               w_dig_valid;
  logic               w_multi;
  logic               w_key_ok;
  logic               w_accept;
  logic               w_commit;
  logic               w_release;

  dec_onehot_enc #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_dec (
    .key_in (key_in),
    .digit  (w_digit),
    .valid  (w_dig_valid),
    .multi  (w_multi)
  );

  // A multi-hot key is only usable when priority resolution is enabled.
  assign w_key_ok  = w_dig_valid && ((PRIORITY_MODE == 1) || !w_multi);
  assign w_accept  = key_valid && key_ready;
  assign w_commit  = (r_state == ACCUM) && enter && !clear;
  assign w_release = (r_state == PRESENT) && r_out_valid && out_ready && !clear;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      unique case (r_state)
        ACCUM:   if (enter)                      w_state_nxt = PRESENT;
        PRESENT: if (r_out_valid && out_ready)   w_state_nxt = ACCUM;
        default:                                 w_state_nxt = ACCUM;
      endcase
    end
  end

  // Combinational handshake output.
  always_comb begin
    key_ready = (r_state == ACCUM) && !enter && !clear;
  end

  // Accumulator, committed result and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_bcd   <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (clear) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_ovf       <= 1'b0;
      end else if (w_commit) begin
        r_out_bcd   <= r_acc;
        r_out_cnt   <= r_cnt;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
      end else begin
        if (w_accept) begin
          if (!w_key_ok) begin
            r_err <= 1'b1;
          end else if (r_cnt < CNT_W'(NUM_DIGITS)) begin
            // Shift form also covers NUM_DIGITS=1 where a slice would be empty.
            r_acc <= (r_acc << DIGIT_W) | ACC_W'(w_digit);
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_ovf <= 1'b1;
          end
        end
        if (w_release) r_out_valid <= 1'b0;
      end
    end
  end

  assign acc_bcd   = r_acc;
  assign acc_count = r_cnt;
  assign out_bcd   = r_out_bcd;
  assign out_count = r_out_cnt;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign ovf       = r_ovf;

endmodule : deci_bcd_accum

// File: tb/tb_deci_bcd_accum.sv
// Self-checking bench for deci_bcd_accum: two instances (PRIORITY_MODE 0 and 1)
// share stimulus; each is compared every cycle against a decimal-arithmetic model.
module tb_deci_bcd_accum;

  localparam int ND = 4;
  localparam int AW = 4 * ND;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    key_in;
  logic          key_valid;
  logic          enter;
  logic          clear;
  logic          out_ready;

  logic          kr [2];
  logic [AW-1:0] ab [2];
  logic [CW-1:0] ac [2];
  logic [AW-1:0] ob [2];
  logic [CW-1:0] oc [2];
  logic          ov [2];
  logic          er [2];
  logic          of [2];

  // Model: accumulator kept as a plain decimal number plus digit count.
  int m_val  [2];
  int m_cnt  [2];
  int m_oval [2];
  int m_ocnt [2];
  bit m_ov   [2];
  bit m_err  [2];
  bit m_ovf  [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  deci_bcd_accum #(.NUM_DIGITS(ND), .PRIORITY_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(kr[0]), .enter(enter), .clear(clear), .acc_bcd(ab[0]),
    .acc_count(ac[0]), .out_bcd(ob[0]), .out_count(oc[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .err(er[0]), .ovf(of[0])
  );

  deci_bcd_accum #(.NUM_DIGITS(ND), .PRIORITY_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(kr[1]), .enter(enter), .clear(clear), .acc_bcd(ab[1]),
    .acc_count(ac[1]), .out_bcd(ob[1]), .out_count(oc[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .err(er[1]), .ovf(of[1])
  );

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] to_bcd(input int v);
    logic [AW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Returns the decoded digit, or -1 for a key that must be rejected.
  function automatic int dec_key(input logic [9:0] k, input int mode);
    int ones;
    int hi;
    ones = 0;
    hi   = -1;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) begin
        ones++;
        hi = i;
      end
    end
    if (ones == 0) return -1;
    if (ones > 1 && mode == 0) return -1;
    return hi;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_cnt[m] = 0; m_oval[m] = 0; m_ocnt[m] = 0;
      m_ov[m] = 0; m_err[m] = 0; m_ovf[m] = 0;
    end
  endtask

  task automatic model_step();
    int d;
    for (int m = 0; m < 2; m++) begin
      d = dec_key(key_in, m);
      m_err[m] = 0;
      if (clear) begin
        m_val[m] = 0; m_cnt[m] = 0; m_ov[m] = 0; m_ovf[m] = 0;
      end else if (!m_ov[m] && enter) begin
        m_oval[m] = m_val[m]; m_ocnt[m] = m_cnt[m]; m_ov[m] = 1;
        m_val[m] = 0; m_cnt[m] = 0;
      end else if (m_ov[m]) begin
        if (out_ready) m_ov[m] = 0;
      end else if (key_valid) begin
        if (d < 0) m_err[m] = 1;
        else if (m_cnt[m] < ND) begin
          m_val[m] = m_val[m] * 10 + d;
          m_cnt[m]++;
        end else m_ovf[m] = 1;
      end
    end
  endtask

  task automatic check_ready();
    for (int m = 0; m < 2; m++)
      chk("key_ready", m, 32'(kr[m]), 32'(!m_ov[m] && !enter && !clear));
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      chk("acc_bcd",   m, 32'(ab[m]), 32'(to_bcd(m_val[m])));
      chk("acc_count", m, 32'(ac[m]), 32'(m_cnt[m]));
      chk("out_bcd",   m, 32'(ob[m]), 32'(to_bcd(m_oval[m])));
      chk("out_count", m, 32'(oc[m]), 32'(m_ocnt[m]));
      chk("out_valid", m, 32'(ov[m]), 32'(m_ov[m]));
      chk("err",       m, 32'(er[m]), 32'(m_err[m]));
      chk("ovf",       m, 32'(of[m]), 32'(m_ovf[m]));
    end
  endtask

  task automatic drive(input bit kv, input logic [9:0] k, input bit en, input bit cl, input bit ordy);
    key_valid = kv; key_in = k; enter = en; clear = cl; out_ready = ordy;
  endtask

  // One clock: ready check before the edge, model update at the edge, outputs after.
  task automatic step();
    #1 check_ready();
    @(posedge clk);
    model_step();
    #1 check_outputs();
  endtask

  task automatic key(input int d);
    drive(1, 10'(1 << d), 0, 0, 0);
    step();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without an edge.
  task automatic do_reset();
    drive(0, '0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_acc_bcd",   m, 32'(ab[m]), 32'h0);
      chk("rst_acc_count", m, 32'(ac[m]), 32'h0);
      chk("rst_out_bcd",   m, 32'(ob[m]), 32'h0);
      chk("rst_out_count", m, 32'(oc[m]), 32'h0);
      chk("rst_out_valid", m, 32'(ov[m]), 32'h0);
      chk("rst_err",       m, 32'(er[m]), 32'h0);
      chk("rst_ovf",       m, 32'(of[m]), 32'h0);
      chk("rst_key_ready", m, 32'(kr[m]), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // Digits 1, 9, 2 then commit.
    key(1); key(9); key(2);
    chk("pin_acc_0192", 0, 32'(ab[0]), 32'h0192);
    chk("pin_cnt_3",    0, 32'(ac[0]), 32'd3);
    drive(0, '0, 1, 0, 0); step();
    chk("pin_out_0192", 0, 32'(ob[0]), 32'h0192);
    chk("pin_ocnt_3",   0, 32'(oc[0]), 32'd3);
    chk("pin_oval_1",   0, 32'(ov[0]), 32'd1);
    chk("pin_acc_zero", 0, 32'(ab[0]), 32'h0);
    drive(0, '0, 0, 0, 1); step();
    chk("pin_oval_0",   0, 32'(ov[0]), 32'd0);

    // Overflow on the fifth digit, sticky across enter, cleared by clear.
    for (int d = 1; d <= 5; d++) key(d);
    chk("pin_acc_1234", 0, 32'(ab[0]), 32'h1234);
    chk("pin_ovf_1",    0, 32'(of[0]), 32'd1);
    drive(0, '0, 1, 0, 0); step();
    drive(0, '0, 0, 0, 1); step();
    chk("pin_ovf_kept", 0, 32'(of[0]), 32'd1);
    drive(0, '0, 0, 1, 0); step();
    chk("pin_ovf_clr",  0, 32'(of[0]), 32'd0);

    // Multi-hot key: error in mode 0, digit 3 in mode 1.
    drive(1, 10'h00C, 0, 0, 0); step();
    chk("pin_err_m0",   0, 32'(er[0]), 32'd1);
    chk("pin_acc_m0",   0, 32'(ab[0]), 32'h0);
    chk("pin_acc_m1",   1, 32'(ab[1]), 32'h0003);
    drive(0, '0, 0, 0, 0); step();
    chk("pin_err_pulse", 0, 32'(er[0]), 32'd0);

    // Stall in PRESENT with a key offered.
    drive(0, '0, 1, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 10'h020, 0, 0, 0); step();
      chk("pin_hold_ob", 1, 32'(ob[1]), 32'h0003);
      chk("pin_hold_ac", 1, 32'(ac[1]), 32'd0);
    end
    drive(0, '0, 0, 0, 1); step();
    drive(0, '0, 0, 0, 0); step();

    // Enter with a concurrent key; then clear with enter.
    key(1);
    drive(1, 10'h080, 1, 0, 0); step();
    chk("pin_out_0001", 0, 32'(ob[0]), 32'h0001);
    chk("pin_ocnt_1",   0, 32'(oc[0]), 32'd1);
    drive(0, '0, 0, 0, 1); step();
    key(5);
    drive(0, '0, 1, 1, 0); step();
    chk("pin_clr_enter", 0, 32'(ov[0]), 32'd0);

    // Reset mid-entry, then commit an empty number.
    key(4); key(7);
    chk("pin_cnt_2", 0, 32'(ac[0]), 32'd2);
    #2 do_reset();
    drive(0, '0, 1, 0, 0); step();
    chk("pin_empty_ocnt", 0, 32'(oc[0]), 32'd0);
    chk("pin_empty_oval", 0, 32'(ov[0]), 32'd1);
    drive(0, '0, 0, 0, 1); step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [9:0] k;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      k = 10'(1 << $urandom_range(0, 9));
      else if (sel < 7) k = '0;
      else              k = 10'($urandom);
      drive($urandom_range(0, 1) == 1, k, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 4) < 2);
      if ($urandom_range(0, 499) == 0) begin
        #1 do_reset();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_deci_bcd_accum
